// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - start/ready request and done/result response bundle for seq_alu
interface seq_alu_if #(
  parameter int N = 64
);
  logic         start;
  logic [3:0]   ALUControl;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         zero;
  logic         div_by_zero;

  modport master (
    output start, ALUControl, a, b,
    input  ready, busy, done, result, zero, div_by_zero
  );

  modport slave (
    input  start, ALUControl, a, b,
    output ready, busy, done, result, zero, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - LEGv8 execute-stage ALU with iterative unsigned MUL/UDIV/UREM
module seq_alu #(
  parameter int N              = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic    clk,
  input  logic    reset,
  seq_alu_if.slave bus
);
  localparam int K  = N / BITS_PER_CYCLE;
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] K_C   = CW'(K);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] M_MUL = 2'd0;
  localparam logic [1:0] M_DIV = 2'd1;
  localparam logic [1:0] M_REM = 2'd2;

  logic [0:0]   state;
  logic [CW-1:0] cnt;
  logic [1:0]   mode;
  // MUL: acc=product, x=a shifted up, y=b shifted down.
  // DIV/REM: acc=remainder, x=dividend shifting into quotient, y=divisor.
  logic [N-1:0] acc, x, y;
  logic [N-1:0] acc_nx, x_nx, y_nx;
  logic [N:0]   r;
  logic [N-1:0] fin;
  logic [N-1:0] sc_result;
  logic         sc_zero, sc_dbz, multi;
  logic [N-1:0] res_q;
  logic         zero_q, dbz_q, done_q;

  always_comb begin
    sc_result = bus.a;
    sc_dbz    = 1'b0;
    multi     = 1'b0;
    case (bus.ALUControl)
      4'b0000: sc_result = bus.a & bus.b;
      4'b0001: sc_result = bus.a | bus.b;
      4'b0010: sc_result = bus.a + bus.b;
      4'b0110: sc_result = bus.a - bus.b;
      4'b0111: sc_result = bus.b;
      4'b1100: sc_result = ~(bus.a | bus.b);
      4'b1111: sc_result = bus.b;
      4'b1000: multi = 1'b1;
      4'b1001: begin
        if (bus.b == '0) begin
          sc_result = '1;
          sc_dbz    = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
      4'b1010: begin
        if (bus.b == '0) sc_dbz = 1'b1;
        else             multi  = 1'b1;
      end
      default: sc_result = bus.a;
    endcase
    sc_zero = (bus.ALUControl == 4'b1111) ? (sc_result != '0) : (sc_result == '0);
  end

  always_comb begin
    acc_nx = acc;
    x_nx   = x;
    y_nx   = y;
    r      = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mode == M_MUL) begin
        if (y_nx[0]) acc_nx = acc_nx + x_nx;
        x_nx = x_nx << 1;
        y_nx = y_nx >> 1;
      end else begin
        // N+1 bits: the shifted-in partial remainder may exceed N bits before the subtract
        r    = {acc_nx, x_nx[N-1]};
        x_nx = x_nx << 1;
        if (r >= {1'b0, y}) begin
          r       = r - {1'b0, y};
          x_nx[0] = 1'b1;
        end
        acc_nx = r[N-1:0];
      end
    end
    fin = (mode == M_DIV) ? x_nx : acc_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode   <= M_MUL;
      acc    <= '0;
      x      <= '0;
      y      <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          if (multi) begin
            state <= RUN;
            cnt   <= K_C;
            acc   <= '0;
            x     <= bus.a;
            y     <= bus.b;
            mode  <= (bus.ALUControl == 4'b1000) ? M_MUL :
                     (bus.ALUControl == 4'b1001) ? M_DIV : M_REM;
          end else begin
            res_q  <= sc_result;
            zero_q <= sc_zero;
            dbz_q  <= sc_dbz;
            done_q <= 1'b1;
          end
        end
      end else begin
        acc <= acc_nx;
        x   <= x_nx;
        y   <= y_nx;
        cnt <= cnt - ONE_C;
        if (cnt == ONE_C) begin
          state  <= IDLE;
          res_q  <= fin;
          zero_q <= (fin == '0);
          dbz_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ready       = (state == IDLE);
  assign bus.busy        = (state == RUN);
  assign bus.done        = done_q;
  assign bus.result      = res_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu with BITS_PER_CYCLE 1 and 4
module tb_seq_alu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.N(64)) if1();
  seq_alu_if #(.N(64)) if4();

  seq_alu #(.N(64), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  seq_alu #(.N(64), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

  typedef struct {
    logic [63:0] r;
    logic        z;
    logic        d;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t m1, m4;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if1.done) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected done", {63'd0, if1.done}, 64'd0);
      end else begin
        m1 = q1.pop_front();
        chk("dut1 result", if1.result, m1.r);
        chk("dut1 zero", {63'd0, if1.zero}, {63'd0, m1.z});
        chk("dut1 div_by_zero", {63'd0, if1.div_by_zero}, {63'd0, m1.d});
        chk("dut1 done cycle", 64'(cyc), 64'(m1.cyc));
      end
    end
    if (if4.done) begin
      if (q4.size() == 0) begin
        chk("dut4 unexpected done", {63'd0, if4.done}, 64'd0);
      end else begin
        m4 = q4.pop_front();
        chk("dut4 result", if4.result, m4.r);
        chk("dut4 zero", {63'd0, if4.zero}, {63'd0, m4.z});
        chk("dut4 done cycle", 64'(cyc), 64'(m4.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] r, input logic z, input logic d, input int lat);
    exp_t e;
    if1.start      = 1'b1;
    if1.ALUControl = op;
    if1.a          = a;
    if1.b          = b;
    e.r = r; e.z = z; e.d = d; e.cyc = cyc + lat;
    q1.push_back(e);
  endtask

  task automatic wait_done(input string name, output int busy_cycles);
    bit seen = 0;
    busy_cycles = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (if1.done) seen = 1;
      else if (if1.busy) busy_cycles++;
    end
    if (!seen) chk(name, 64'd0, 64'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ready"},  {63'd0, if1.ready}, 64'd1);
    chk({tag, " busy"},   {63'd0, if1.busy}, 64'd0);
    chk({tag, " done"},   {63'd0, if1.done}, 64'd0);
    chk({tag, " result"}, if1.result, 64'd0);
    chk({tag, " zero"},   {63'd0, if1.zero}, 64'd0);
    chk({tag, " dbz"},    {63'd0, if1.div_by_zero}, 64'd0);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int nb;
    int ndone;
    exp_t e4;
    if1.start = 1'b0; if1.ALUControl = 4'd0; if1.a = '0; if1.b = '0;
    if4.start = 1'b0; if4.ALUControl = 4'd0; if4.a = '0; if4.b = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    chk("reset dut4 ready", {63'd0, if4.ready}, 64'd1);
    reset = 1'b1;

    issue(4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1);          step();
    issue(4'b0110, 64'd3, 64'd3, 64'd0, 1'b1, 1'b0, 1);           step();
    issue(4'b1111, 64'd4, 64'd0, 64'd0, 1'b0, 1'b0, 1);           step();
    issue(4'b1111, 64'd4, 64'd9, 64'd9, 1'b1, 1'b0, 1);           step();
    issue(4'b0101, 64'h55, 64'd3, 64'h55, 1'b0, 1'b0, 1);         step();
    issue(4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1);  step();
    issue(4'b0001, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1'b0, 1);  step();
    issue(4'b1100, 64'd0, 64'd0, ONES, 1'b0, 1'b0, 1);            step();
    issue(4'b0111, 64'd5, 64'd0, 64'd0, 1'b1, 1'b0, 1);           step();
    issue(4'b1001, 64'd100, 64'd0, ONES, 1'b0, 1'b1, 1);          step();
    issue(4'b0010, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1);           step();
    issue(4'b1010, 64'd100, 64'd0, 64'd100, 1'b0, 1'b1, 1);       step();
    issue(4'b0110, 64'd0, 64'd1, ONES, 1'b0, 1'b0, 1);            step();
    if1.start = 1'b0;
    step();

    issue(4'b1000, 64'hFFFF_FFFF, 64'h1_0000_0001, ONES, 1'b0, 1'b0, 65);
    if4.start = 1'b1; if4.ALUControl = 4'b1000;
    if4.a = 64'hFFFF_FFFF; if4.b = 64'h1_0000_0001;
    e4.r = ONES; e4.z = 1'b0; e4.d = 1'b0; e4.cyc = cyc + 17;
    q4.push_back(e4);
    step();
    if1.start = 1'b0; if4.start = 1'b0;
    if1.a = '0; if1.b = '0; if4.a = '0; if4.b = '0;
    wait_done("mul done timeout", nb);
    chk("mul busy cycles", 64'(nb), 64'd64);

    issue(4'b1001, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 65);
    step();
    if1.start = 1'b0;
    repeat (10) step();
    if1.start = 1'b1; if1.ALUControl = 4'b0010; if1.a = 64'd1; if1.b = 64'd1;
    step();
    if1.start = 1'b0;
    wait_done("udiv done timeout", nb);

    issue(4'b1010, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, 65);
    step();
    if1.start = 1'b0;
    wait_done("urem done timeout", nb);
    repeat (3) step();
    chk("urem result holds", if1.result, 64'd2);

    if1.start = 1'b1; if1.ALUControl = 4'b1000; if1.a = 64'd3; if1.b = 64'd5;
    step();
    if1.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk_reset_state("abort");
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (if1.done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);

    chk("dut1 queue empty", 64'(q1.size()), 64'd0);
    chk("dut4 queue empty", 64'(q4.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the execute stage of the pipelined LEGv8 processor. It covers every single-cycle ALUControl operation and adds iterative unsigned multiply, divide and remainder. Operations are accepted with a start/ready handshake, and completion is reported with a one-cycle done pulse. The hazard unit stalls the pipeline while busy is high.

## Interface
- N, default 64: operand and result width.
- BITS_PER_CYCLE, default 1: bits retired per iteration of MUL/UDIV/UREM. Legal values are 1, 2 and 4, and N must be divisible by BITS_PER_CYCLE.
- clk  input  1: clock; all state changes on the rising edge.
- reset  input  1: synchronous, active-low reset.
- start  input  1: operation request; sampled only while ready=1.
- ALUControl  input  4: operation select, captured together with start.
- a, b  input  N: operands, captured together with start.
- ready  output  1: block can accept start this cycle.
- busy  output  1: multi-cycle operation in progress.
- done  output  1: one-cycle pulse; result and zero are valid in this cycle.
- result  output  N: registered result; holds until the next done.
- zero  output  1: registered zero flag; holds until the next done.
- div_by_zero  output  1: registered; set on a UDIV/UREM done when b==0, cleared on any other done.

## Operation
- Opcodes:
  - 0000 a&b
  - 0001 a|b
  - 0010 a+b
  - 0110 a-b
  - 0111 b
  - 1100 ~(a|b)
  - 1111 b (CBNZ)
  - 1000 MUL: low N bits of unsigned a*b
  - 1001 UDIV: unsigned a/b
  - 1010 UREM: unsigned a%b
  - Any other code returns result a.
- All arithmetic is modulo 2^N. Carry out of ADD/SUB and the high half of the MUL product are discarded.
- zero = (result==0) for every opcode except 1111, where zero = (result!=0).
- Divide by zero (UDIV/UREM with b==0):
  - UDIV result is all ones; UREM result is a.
  - div_by_zero=1.
  - Completes in a single cycle, with no iteration.
- FSM states: IDLE and RUN.
  - IDLE: ready=1, busy=0.
  - start with a single-cycle opcode, or with UDIV/UREM and b==0: compute and register result/zero, pulse done, stay in IDLE.
  - start with MUL/UDIV/UREM (b!=0): latch the operands, clear the accumulator/remainder, load the iteration counter with K=N/BITS_PER_CYCLE, go to RUN.
  - RUN: ready=0, busy=1. Each cycle retires BITS_PER_CYCLE bits and decrements the counter:
    - MUL: shift-add, LSB-first over b.
    - UDIV/UREM: restoring division, MSB-first over a.
  - On the iteration where the counter reaches 0: register result/zero, pulse done, return to IDLE.
- start while in RUN is ignored. The operation in progress is not disturbed, and no request is queued.
- a, b and ALUControl may change freely after capture; only the latched copies are used.

## Timing
- Reset (reset=0 at an edge) forces the following after that edge:
  - FSM state IDLE, iteration counter 0
  - ready=1, busy=0, done=0
  - result=0, zero=0, div_by_zero=0
- Reset overrides start in the same cycle.
- Reset mid-RUN aborts the operation. No done is produced and the partial result is discarded.
- Single-cycle ops (including divide by zero): start accepted at edge t gives done=1 and a valid result in the cycle after edge t, i.e. latency 1. Back-to-back starts on consecutive cycles give done on consecutive cycles.
- MUL/UDIV/UREM with b!=0:
  - start accepted at edge t; busy=1 from after edge t.
  - The last iteration happens at edge t+K. done=1, busy=0 and ready=1 from after edge t+K, so latency is K cycles.
  - A new start may be issued in the done cycle.
- done is never high for two consecutive cycles from the same operation.
- busy and ready are mutually exclusive and decoded directly from the FSM state register.

## Test plan
Run with N=64, BITS_PER_CYCLE=1 unless noted.
- ADD a=5, b=7, then SUB a=3, b=3 on consecutive cycles -> done pulses on two consecutive cycles with result=12, zero=0, then result=0, zero=1.
- Op 1111 with b=0, then b=9 -> zero=0, then zero=1. Op 0101 with a=0x55 -> result=0x55.
- MUL a=0xFFFFFFFF, b=0x100000001:
  - -> result=0xFFFFFFFFFFFFFFFF, done exactly 64 cycles after start, busy high for those 64 cycles.
  - With BITS_PER_CYCLE=4 -> same result after 16 cycles.
- UDIV a=100, b=7 -> result=14, div_by_zero=0. UREM with the same operands -> result=2.
- UDIV a=100, b=0 -> done after 1 cycle, result=0xFFFFFFFFFFFFFFFF, div_by_zero=1. The next ADD clears div_by_zero.
- MUL started, reset asserted at iteration 30 -> after that edge all outputs hold their reset values (ready=1, busy=0, done=0, result=0, zero=0, div_by_zero=0), and no done follows. A second start pulsed during a later RUN is ignored, and the first result is unchanged.
